// File: rtl/ft245_fifo_bridge.sv
// FT245-style asynchronous USB FIFO bus master: moves bytes between the chip
// pins and internal RX/TX FIFOs, with strobe timing, fair arbitration and loopback.
module ft245_fifo_bridge #(
    parameter int unsigned RX_DEPTH     = 16,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned RD_CYCLES    = 2,
    parameter int unsigned WR_CYCLES    = 2,
    parameter int unsigned RECOV_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxf,
    input  logic                      txe,
    output logic                      rd,
    output logic                      wr,
    inout  wire  [7:0]                data,
    input  logic                      loopback,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count
);
    localparam int unsigned RX_AW   = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW   = $clog2(TX_DEPTH);
    localparam int unsigned RX_CW   = RX_AW + 1;
    localparam int unsigned TX_CW   = TX_AW + 1;
    localparam int unsigned RW_MAX  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CYC_MAX = (RW_MAX > RECOV_CYCLES) ? RW_MAX : RECOV_CYCLES;
    localparam int unsigned TW      = $clog2(CYC_MAX);

    localparam logic [TW-1:0] RD_LAST    = TW'(RD_CYCLES - 1);
    localparam logic [TW-1:0] WR_LAST    = TW'(WR_CYCLES - 1);
    localparam logic [TW-1:0] RECOV_LAST = TW'(RECOV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACT,
        S_WR_ACT,
        S_WR_HOLD,
        S_RECOV
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           last_wr_q, last_wr_d;
    logic [1:0]     rxf_sync_q, txe_sync_q;
    logic           rxf_s, txe_s;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           oe_q, oe_d;
    logic [7:0]     dout_q;
    logic           rd_req, wr_req;
    logic           bus_push, bus_pop;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
    logic [RX_CW-1:0] rx_cnt_q;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
    logic [TX_CW-1:0] tx_cnt_q;

    logic       rx_nonempty, tx_notfull;
    logic       rx_push, rx_pop, tx_push, tx_pop, lb_xfer;
    logic [7:0] tx_wdata;

    assign rxf_s  = rxf_sync_q[1];
    assign txe_s  = txe_sync_q[1];
    assign rd_req = !rxf_s && (rx_cnt_q < RX_CW'(RX_DEPTH));
    assign wr_req = !txe_s && (tx_cnt_q != '0);

    // State register, synchronisers and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            last_wr_q  <= 1'b1;
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
            rd_q       <= 1'b1;
            wr_q       <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            last_wr_q  <= last_wr_d;
            rxf_sync_q <= {rxf_sync_q[0], rxf};
            txe_sync_q <= {txe_sync_q[0], txe};
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            dout_q     <= tx_mem[tx_rp_q];
        end
    end

    // Next-state: on a tie the side not served last time wins
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        last_wr_d = last_wr_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req && (!wr_req || last_wr_q)) begin
                    state_d   = S_RD_ACT;
                    tmr_d     = '0;
                    last_wr_d = 1'b0;
                end else if (wr_req) begin
                    state_d   = S_WR_ACT;
                    tmr_d     = '0;
                    last_wr_d = 1'b1;
                end
            end
            S_RD_ACT: begin
                if (tmr_q == RD_LAST) begin
                    state_d = S_RECOV;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WR_ACT: begin
                if (tmr_q == WR_LAST) begin
                    state_d = S_WR_HOLD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WR_HOLD: begin
                state_d = S_RECOV;
                tmr_d   = '0;
            end
            S_RECOV: begin
                if (tmr_q == RECOV_LAST) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs: pin levels follow the state being entered, so they are registered
    always_comb begin
        rd_d     = (state_d != S_RD_ACT);
        wr_d     = (state_d == S_WR_ACT);
        oe_d     = (state_d == S_WR_ACT) || (state_d == S_WR_HOLD);
        bus_push = (state_q == S_RD_ACT) && (tmr_q == RD_LAST);
        bus_pop  = (state_q == S_WR_HOLD);
    end

    assign rd   = rd_q;
    assign wr   = wr_q;
    assign data = oe_q ? dout_q : 8'hzz;

    assign rx_nonempty = (rx_cnt_q != '0);
    assign tx_notfull  = (tx_cnt_q < TX_CW'(TX_DEPTH));
    assign rx_valid    = !rst && !loopback && rx_nonempty;
    assign tx_ready    = !rst && !loopback && tx_notfull;
    assign lb_xfer     = !rst && loopback && rx_nonempty && tx_notfull;

    assign rx_push  = !rst && bus_push;
    assign rx_pop   = (rx_valid && rx_ready) || lb_xfer;
    assign tx_push  = (tx_valid && tx_ready) || lb_xfer;
    assign tx_pop   = !rst && bus_pop;
    assign tx_wdata = loopback ? rx_data : tx_data;

    assign rx_data  = rx_mem[rx_rp_q];
    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;

    // FIFO storage has no reset; pointers and counts define validity
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= data;
        if (tx_push) tx_mem[tx_wp_q] <= tx_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RX_AW'(1);
            if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TX_AW'(1);
            rx_cnt_q <= rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
            tx_cnt_q <= tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end
    end

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Bench for ft245_fifo_bridge: a behavioural FT245 chip model plus byte-order
// queues checked against the bridge's user streams and pin activity.
module tb_ft245_fifo_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txe = 1'b1;
    logic       loopback = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rxf;
    logic       rd, wr, rx_valid, tx_ready;
    logic [7:0] rx_data;
    logic [4:0] rx_count, tx_count;
    wire  [7:0] data;

    int vec_n = 0;
    int err_n = 0;

    // Chip model: holds chip_len bytes for the host, rxf low while any remain
    logic [7:0] chip_mem [256];
    int         chip_len = 0;
    int         chip_idx = 0;
    logic [7:0] chip_byte = 8'h00;
    logic       mon_en = 1'b0;

    assign rxf  = (chip_idx >= chip_len);
    assign data = rd ? 8'hzz : chip_byte;

    // Pin log: 1 = read strobe, 2 = write strobe, with widths and idle gaps
    int         ev [512];
    int         gap [512];
    int         ev_n = 0;
    int         rd_w [256];
    int         rd_n = 0;
    int         wr_w [256];
    logic [7:0] wr_b [256];
    int         wr_n = 0;
    int         rd_run = 0;
    int         wr_run = 0;
    int         idle_run = 0;
    int         overlap_n = 0;

    ft245_fifo_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .rxf      (rxf),
        .txe      (txe),
        .rd       (rd),
        .wr       (wr),
        .data     (data),
        .loopback (loopback),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rd && wr) overlap_n++;
            if (!rd) begin
                if (rd_run == 0) begin
                    ev[ev_n] = 1; gap[ev_n] = idle_run; ev_n++;
                end
                rd_run++;
            end else if (rd_run > 0) begin
                rd_w[rd_n] = rd_run; rd_n++; rd_run = 0; chip_idx++;
            end
            if (wr) begin
                if (wr_run == 0) begin
                    ev[ev_n] = 2; gap[ev_n] = idle_run; ev_n++;
                end
                wr_run++;
            end else if (wr_run > 0) begin
                wr_w[wr_n] = wr_run; wr_b[wr_n] = data; wr_n++; wr_run = 0;
            end
            if (rd && !wr) idle_run++;
            else idle_run = 0;
            chip_byte = chip_mem[8'(chip_idx)];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic chip_add(input logic [7:0] b);
        chip_mem[8'(chip_len)] = b;
        chip_len++;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        step(); step(); step();
        vec_n++; if (rd !== 1'b1) begin err_n++; $display("FAIL reset_rd: got %b expected 1", rd); end
        vec_n++; if (wr !== 1'b0) begin err_n++; $display("FAIL reset_wr: got %b expected 0", wr); end
        vec_n++; if (rx_valid !== 1'b0) begin err_n++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vec_n++; if (tx_ready !== 1'b0) begin err_n++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        vec_n++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
            err_n++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        vec_n++; if (tx_ready !== 1'b1) begin err_n++; $display("FAIL post_reset_tx_ready: got %b expected 1", tx_ready); end
        // Reset in the middle of a write strobe
        push_tx(8'h3C);
        txe = 1'b0;
        for (int i = 0; i < 20 && wr !== 1'b1; i++) step();
        vec_n++; if (wr !== 1'b1) begin err_n++; $display("FAIL wr_act_reach: got wr=%b expected 1", wr); end
        rst = 1'b1;
        step();
        vec_n++; if (rd !== 1'b1 || wr !== 1'b0) begin
            err_n++; $display("FAIL midwr_reset_pins: got rd=%b wr=%b expected rd=1 wr=0", rd, wr); end
        vec_n++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
            err_n++; $display("FAIL midwr_reset_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
        vec_n++; if (tx_ready !== 1'b0) begin err_n++; $display("FAIL midwr_reset_tx_ready: got %b expected 0", tx_ready); end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wr !== 1'b0) bad++;
        end
        vec_n++; if (bad != 0 || tx_count !== 5'd0) begin
            err_n++; $display("FAIL aborted_write_resumed: got %0d wr-high cycles, tx_count=%0d expected 0/0", bad, tx_count); end
        txe = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int rb = rd_n;
        chip_add(8'h08);
        step();
        vec_n++; if (rd !== 1'b1) begin err_n++; $display("FAIL rd_latency_1: got %b expected 1", rd); end
        step();
        vec_n++; if (rd !== 1'b1) begin err_n++; $display("FAIL rd_latency_2: got %b expected 1", rd); end
        step();
        vec_n++; if (rd !== 1'b0) begin err_n++; $display("FAIL rd_latency_3: got %b expected 0", rd); end
        for (int i = 0; i < 20 && rx_valid !== 1'b1; i++) step();
        vec_n++; if (rx_valid !== 1'b1 || rx_data !== 8'h08) begin
            err_n++; $display("FAIL single_read_data: got valid=%b data=%h expected 1/08", rx_valid, rx_data); end
        vec_n++; if (rx_count !== 5'd1) begin err_n++; $display("FAIL single_read_count: got %0d expected 1", rx_count); end
        step(); step(); step(); step(); step(); step();
        vec_n++; if (rd_n - rb != 1 || rd_w[rb] != 2) begin
            err_n++; $display("FAIL single_read_strobe: got %0d reads width %0d expected 1 read width 2", rd_n - rb, rd_w[rb]); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        vec_n++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
            err_n++; $display("FAIL single_read_pop: got count=%0d valid=%b expected 0/0", rx_count, rx_valid); end
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp_q [$];
        int rb = rd_n;
        int bad = 0;
        int got = 0;
        rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b = 8'($urandom);
            exp_q.push_back(b);
            chip_add(b);
        end
        for (int i = 0; i < 400 && rx_count !== 5'd16; i++) step();
        for (int i = 0; i < 30; i++) begin
            step();
            if (rd !== 1'b1) bad++;
        end
        vec_n++; if (rx_count !== 5'd16) begin err_n++; $display("FAIL rx_full_count: got %0d expected 16", rx_count); end
        vec_n++; if (rd_n - rb != 16 || bad != 0) begin
            err_n++; $display("FAIL rx_full_reads: got %0d reads, %0d rd-low cycles when full expected 16/0", rd_n - rb, bad); end
        for (int i = 0; i < 600 && got < 20; i++) begin
            if (rx_valid === 1'b1) begin
                vec_n++; if (rx_data !== exp_q[got]) begin
                    err_n++; $display("FAIL rx_order[%0d]: got %h expected %h", got, rx_data, exp_q[got]); end
                got++;
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
            step();
        end
        rx_ready = 1'b0;
        vec_n++; if (got != 20 || rx_count !== 5'd0) begin
            err_n++; $display("FAIL rx_drain: got %0d bytes count=%0d expected 20/0", got, rx_count); end
        step(); step(); step(); step();
    endtask

    task automatic test_write();
        int wb = wr_n;
        txe = 1'b1;
        push_tx(8'hA5);
        push_tx(8'h5A);
        vec_n++; if (tx_count !== 5'd2) begin err_n++; $display("FAIL tx_count_two: got %0d expected 2", tx_count); end
        for (int i = 0; i < 20; i++) step();
        vec_n++; if (wr_n != wb || tx_count !== 5'd2) begin
            err_n++; $display("FAIL txe_high_hold: got %0d writes count=%0d expected 0/2", wr_n - wb, tx_count); end
        txe = 1'b0;
        for (int i = 0; i < 100 && wr_n < wb + 2; i++) step();
        step();
        vec_n++; if (wr_n - wb != 2 || wr_w[wb] != 2 || wr_w[wb+1] != 2) begin
            err_n++; $display("FAIL wr_pulses: got %0d pulses widths %0d,%0d expected 2 of width 2", wr_n - wb, wr_w[wb], wr_w[wb+1]); end
        vec_n++; if (wr_b[wb] !== 8'hA5 || wr_b[wb+1] !== 8'h5A) begin
            err_n++; $display("FAIL wr_data: got %h,%h expected a5,5a", wr_b[wb], wr_b[wb+1]); end
        vec_n++; if (tx_count !== 5'd0) begin err_n++; $display("FAIL tx_drained: got %0d expected 0", tx_count); end
        txe = 1'b1;
        step(); step(); step(); step();
    endtask

    task automatic test_tx_full();
        logic [7:0] exp_q [$];
        int wb = wr_n;
        int bad = 0;
        txe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = 8'($urandom);
            if (tx_ready !== 1'b1) bad++;
            exp_q.push_back(b);
            push_tx(b);
        end
        vec_n++; if (bad != 0 || tx_count !== 5'd16 || tx_ready !== 1'b0) begin
            err_n++; $display("FAIL tx_full: got count=%0d ready=%b stalls=%0d expected 16/0/0", tx_count, tx_ready, bad); end
        txe = 1'b0;
        for (int i = 0; i < 400 && wr_n < wb + 16; i++) step();
        vec_n++; if (wr_n - wb != 16) begin err_n++; $display("FAIL tx_full_writes: got %0d expected 16", wr_n - wb); end
        for (int i = 0; i < 16; i++) begin
            vec_n++; if (wr_b[wb+i] !== exp_q[i]) begin
                err_n++; $display("FAIL tx_order[%0d]: got %h expected %h", i, wr_b[wb+i], exp_q[i]); end
        end
        txe = 1'b1;
        step(); step(); step(); step();
    endtask

    task automatic test_arbitration();
        logic [7:0] tx_q [$];
        logic [7:0] rx_q [$];
        int rb, wb, eb;
        int got = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        txe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b = 8'($urandom);
            tx_q.push_back(b);
            push_tx(b);
        end
        rb = rd_n; wb = wr_n; eb = ev_n;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b = 8'($urandom);
            rx_q.push_back(b);
            chip_add(b);
        end
        txe = 1'b0;
        for (int i = 0; i < 300 && (rd_n < rb + 4 || wr_n < wb + 4); i++) step();
        step(); step();
        for (int k = 0; k < 8; k++) begin
            vec_n++; if (ev[eb+k] != ((k % 2 == 0) ? 1 : 2)) begin
                err_n++; $display("FAIL arb_order[%0d]: got %0d expected %0d (1=rd 2=wr)", k, ev[eb+k], (k % 2 == 0) ? 1 : 2); end
        end
        // Each transfer is followed by the recovery time plus one arbitration cycle
        for (int k = 1; k < 8; k++) begin
            vec_n++; if (gap[eb+k] < 4) begin
                err_n++; $display("FAIL arb_gap[%0d]: got %0d idle cycles expected >= 4", k, gap[eb+k]); end
        end
        for (int i = 0; i < 4; i++) begin
            vec_n++; if (wr_b[wb+i] !== tx_q[i]) begin
                err_n++; $display("FAIL arb_wr[%0d]: got %h expected %h", i, wr_b[wb+i], tx_q[i]); end
        end
        for (int i = 0; i < 100 && got < 4; i++) begin
            if (rx_valid === 1'b1) begin
                vec_n++; if (rx_data !== rx_q[got]) begin
                    err_n++; $display("FAIL arb_rd[%0d]: got %h expected %h", got, rx_data, rx_q[got]); end
                got++;
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
            step();
        end
        rx_ready = 1'b0;
        vec_n++; if (got != 4) begin err_n++; $display("FAIL arb_rd_count: got %0d expected 4", got); end
        txe = 1'b1;
        step(); step(); step(); step();
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q [$];
        int wb;
        int bad_v = 0;
        int bad_r = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        loopback = 1'b1;
        txe = 1'b0;
        wb = wr_n;
        exp_q.push_back(8'h08);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) chip_add(exp_q[i]);
        for (int i = 0; i < 400 && wr_n < wb + 4; i++) begin
            step();
            if (rx_valid !== 1'b0) bad_v++;
            if (tx_ready !== 1'b0) bad_r++;
        end
        vec_n++; if (bad_v != 0 || bad_r != 0) begin
            err_n++; $display("FAIL loop_user_gated: got %0d rx_valid / %0d tx_ready cycles expected 0/0", bad_v, bad_r); end
        vec_n++; if (wr_n - wb != 4) begin err_n++; $display("FAIL loop_writes: got %0d expected 4", wr_n - wb); end
        for (int i = 0; i < 4; i++) begin
            vec_n++; if (wr_b[wb+i] !== exp_q[i]) begin
                err_n++; $display("FAIL loop_data[%0d]: got %h expected %h", i, wr_b[wb+i], exp_q[i]); end
        end
        step(); step();
        vec_n++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
            err_n++; $display("FAIL loop_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
        loopback = 1'b0;
        txe = 1'b1;
        step();
        vec_n++; if (tx_ready !== 1'b1) begin err_n++; $display("FAIL loop_exit_ready: got %b expected 1", tx_ready); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rx_fill();
        test_write();
        test_tx_full();
        test_arbitration();
        test_loopback();
        vec_n++; if (overlap_n != 0) begin
            err_n++; $display("FAIL strobe_overlap: got %0d cycles with rd and wr active expected 0", overlap_n); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
